gpo_timed_queue: RTL

//  Timestamped event queue feeding GPO_Core (drives its counter_matched and gpo_in).

---
 rtl/gpo_timed_queue_if.sv | 30 +++
 rtl/gpo_timed_queue.sv | 112 +++++++++++
 2 files changed

// File: rtl/gpo_timed_queue_if.sv
// Bus bundle between the AXI-side writer/time base and the timed GPO queue.
// The master side feeds words and time; the slave side is the queue itself.
interface gpo_timed_queue_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  wr_en;
   logic [127:0]          wr_data;
   logic                  flush;
   logic [63:0]           counter_value;
   logic                  counter_matched;
   logic [127:0]          gpo_data;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   occupancy;
   logic                  overflow_error;
   logic                  late_error;
   logic [127:0]          late_data;

   modport master (
      output wr_en, wr_data, flush, counter_value,
      input  counter_matched, gpo_data, full, empty, occupancy,
             overflow_error, late_error, late_data
   );

   modport slave (
      input  wr_en, wr_data, flush, counter_value,
      output counter_matched, gpo_data, full, empty, occupancy,
             overflow_error, late_error, late_data
   );
endinterface

// File: rtl/gpo_timed_queue.sv
// Timestamped word queue: a circular RAM feeds a head register whose timestamp is
// compared against the global time counter to fire the word or drop it as late.
//
// state      | meaning
// HEAD_EMPTY | head register holds no word; loads from RAM when storage is non-empty
// HEAD_HOLD  | head register valid; waiting, firing or dropping against counter_value
module gpo_timed_queue #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic               CLK100MHZ,
   input  logic               reset,
   gpo_timed_queue_if.slave   q
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {HEAD_EMPTY, HEAD_HOLD} head_state_e;

   head_state_e           state_q, state_d;
   logic [127:0]          mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [127:0]          head_q, head_d;
   logic [127:0]          gpo_q, gpo_d, late_data_q, late_data_d;
   logic                  matched_q, matched_d, late_q, late_d, ovf_q, ovf_d;
   logic                  fifo_empty, fifo_full, head_valid, fire, late, push, load;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                       (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign head_valid = (state_q == HEAD_HOLD);
   assign fire       = head_valid && (head_q[127:64] == q.counter_value);
   assign late       = head_valid && (head_q[127:64] <  q.counter_value);
   // full is judged before any same-edge pop, so a write into a full FIFO is lost
   assign push       = q.wr_en && !fifo_full && !q.flush;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      head_d      = head_q;
      gpo_d       = gpo_q;
      late_data_d = late_data_q;
      matched_d   = 1'b0;
      late_d      = 1'b0;
      ovf_d       = 1'b0;
      load        = 1'b0;
      if (q.flush) begin
         state_d  = HEAD_EMPTY;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         matched_d = fire;
         late_d    = late;
         ovf_d     = q.wr_en && fifo_full;
         if (fire) gpo_d = head_q;
         if (late) late_data_d = head_q;
         case (state_q)
            HEAD_EMPTY: load = !fifo_empty;
            HEAD_HOLD: begin
               if (fire || late) begin
                  if (!fifo_empty) load = 1'b1;
                  else             state_d = HEAD_EMPTY;
               end
            end
            default: state_d = HEAD_EMPTY;
         endcase
         if (load) begin
            head_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = HEAD_HOLD;
         end
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_q     <= HEAD_EMPTY;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         head_q      <= '0;
         gpo_q       <= '0;
         late_data_q <= '0;
         matched_q   <= 1'b0;
         late_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         head_q      <= head_d;
         gpo_q       <= gpo_d;
         late_data_q <= late_data_d;
         matched_q   <= matched_d;
         late_q      <= late_d;
         ovf_q       <= ovf_d;
      end
   end

   // storage itself needs no reset; the pointers define what is valid
   always_ff @(posedge CLK100MHZ) begin
      if (push && !reset) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= q.wr_data;
   end

   assign q.counter_matched = matched_q;
   assign q.gpo_data        = gpo_q;
   assign q.late_error      = late_q;
   assign q.late_data       = late_data_q;
   assign q.overflow_error  = ovf_q;
   assign q.full            = fifo_full;
   assign q.empty           = fifo_empty && !head_valid;
   assign q.occupancy       = wr_ptr_q - rd_ptr_q;
endmodule
